// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream for fifo_stream_reader.
// master = the reader, slave = FIFO/sink side.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             i_en;
  logic             i_empty;
  logic             o_ren;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_last;

  modport master (
    input  i_en,
    input  i_empty,
    input  i_data,
    input  i_ready,
    output o_ren,
    output o_valid,
    output o_data,
    output o_last
  );

  modport slave (
    output i_en,
    output i_empty,
    output i_data,
    output i_ready,
    input  o_ren,
    input  o_valid,
    input  o_data,
    input  o_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: 2-entry skid buffer hides the registered read
// latency, delivers 1 word/clk on a valid/ready stream with packet framing.
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rest,
  fifo_stream_reader_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(PKT_LEN - 1);

  logic             infl;
  logic [1:0]       occ;
  logic [1:0]       fill;
  logic [WIDTH-1:0] buf0;
  logic [WIDTH-1:0] buf1;
  logic [CNT_W-1:0] cnt;
  logic             valid;
  logic             pop;
  logic             ren;

  assign valid = (occ != 2'd0);
  assign pop   = valid & bus.i_ready;
  assign fill  = occ + {1'b0, infl};

  // Reads in flight count against capacity so the buffer never overflows.
  assign ren = bus.i_en & ~bus.i_empty & ~i_rest &
               ((fill < 2'd2) | pop);

  assign bus.o_ren   = ren;
  assign bus.o_valid = valid;
  assign bus.o_data  = buf0;
  assign bus.o_last  = valid & (cnt == LAST_BEAT);

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      infl <= 1'b0;
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
      cnt  <= '0;
    end else begin
      infl <= ren;
      occ  <= fill - {1'b0, pop};
      if (pop) begin
        buf0 <= buf1;
        if (infl) begin
          if (occ == 2'd1) buf0 <= bus.i_data;
          else             buf1 <= bus.i_data;
        end
      end else if (infl) begin
        if (occ == 2'd0) buf0 <= bus.i_data;
        else             buf1 <= bus.i_data;
      end
      if (pop) begin
        if (cnt == LAST_BEAT) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
